// File: rtl/lfsr_gen.sv
// Handshaked Fibonacci XNOR LFSR with multi-step advance and a step counter.
// Optional all-ones lockup detection (LOCKED state) is built when LFSR_LOCKUP_EN is defined.
module lfsr_gen #(
    parameter int                 WIDTH = 64,
    parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(64'hD800_0000_0000_0000),
    parameter int                 STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             enable,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             lockup,
    output logic [31:0]      step_count
);

    typedef enum logic [1:0] {IDLE, RUN, LOCKED} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             lock_cond;
    logic             advance;

    // STEP chained single shifts, all resolved inside one clock
    function automatic logic [WIDTH-1:0] lfsr_adv(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        for (int i = 0; i < STEP; i++) begin
            r = {r[WIDTH-2:0], ~^(r & TAPS)};
        end
        return r;
    endfunction

`ifdef LFSR_LOCKUP_EN
    assign lock_cond = (fsm_q == RUN) && (&state_q);
`else
    assign lock_cond = 1'b0;
`endif

    assign advance    = out_valid && out_ready && !load;
    assign out_data   = state_q;
    assign step_count = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= seed;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = seed;
            cnt_d   = '0;
        end else if (advance) begin
            state_d = lfsr_adv(state_q);
            cnt_d   = cnt_q + 32'd1;
        end
        unique case (fsm_q)
            IDLE:    fsm_d = enable ? RUN : IDLE;
            RUN: begin
                if (load)           fsm_d = enable ? RUN : IDLE;
                else if (lock_cond) fsm_d = LOCKED;
                else                fsm_d = enable ? RUN : IDLE;
            end
            LOCKED:  fsm_d = load ? (enable ? RUN : IDLE) : LOCKED;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (fsm_q == RUN) && !lock_cond;
`ifdef LFSR_LOCKUP_EN
        lockup    = (fsm_q == LOCKED);
`else
        lockup    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 64-bit instance plus an 8-bit, 8-step instance.
// Lockup expectations follow whether LFSR_LOCKUP_EN is defined for the build.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_load, a_enable, a_ready;
    logic [63:0] a_seed, a_data;
    logic        a_valid, a_lockup;
    logic [31:0] a_cnt;

    logic        b_reset, b_load, b_enable, b_ready;
    logic [7:0]  b_seed, b_data;
    logic        b_valid, b_lockup;
    logic [31:0] b_cnt;

    lfsr_gen dut_a (
        .clk(clk), .reset(a_reset), .seed(a_seed), .load(a_load), .enable(a_enable),
        .out_ready(a_ready), .out_data(a_data), .out_valid(a_valid), .lockup(a_lockup),
        .step_count(a_cnt)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .STEP(8)) dut_b (
        .clk(clk), .reset(b_reset), .seed(b_seed), .load(b_load), .enable(b_enable),
        .out_ready(b_ready), .out_data(b_data), .out_valid(b_valid), .lockup(b_lockup),
        .step_count(b_cnt)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b1; a_load = 1'b0; a_enable = 1'b0; a_ready = 1'b1; a_seed = 64'h0;
        b_reset = 1'b1; b_load = 1'b0; b_enable = 1'b0; b_ready = 1'b1; b_seed = 8'h0;
        tick();
        a_reset = 1'b0; b_reset = 1'b0;

        chk("rst_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_lockup", {63'd0, a_lockup}, 64'd0);
        chk("rst_cnt", {32'd0, a_cnt}, 64'd0);
        chk("rst_data", a_data, 64'h0);

        a_enable = 1'b1;
        tick();
        chk("run_valid", {63'd0, a_valid}, 64'd1);
        chk("seq0_data", a_data, 64'h0);
        chk("seq0_cnt", {32'd0, a_cnt}, 64'd0);
        tick();
        chk("seq1_data", a_data, 64'h1);
        chk("seq1_cnt", {32'd0, a_cnt}, 64'd1);
        tick();
        chk("seq2_data", a_data, 64'h3);
        chk("seq2_cnt", {32'd0, a_cnt}, 64'd2);

        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", a_data, 64'h3);
            chk("stall_cnt", {32'd0, a_cnt}, 64'd2);
            chk("stall_valid", {63'd0, a_valid}, 64'd1);
        end
        a_ready = 1'b1;
        tick();
        chk("seq3_data", a_data, 64'h7);
        chk("seq3_cnt", {32'd0, a_cnt}, 64'd3);
        tick();
        chk("seq4_data", a_data, 64'hF);
        chk("seq4_cnt", {32'd0, a_cnt}, 64'd4);

        // load beats a simultaneous accept
        a_load = 1'b1; a_seed = 64'h1234;
        tick();
        a_load = 1'b0;
        chk("load_data", a_data, 64'h1234);
        chk("load_cnt", {32'd0, a_cnt}, 64'd0);
        chk("load_valid", {63'd0, a_valid}, 64'd1);
        tick();
        chk("post_load_data", a_data, 64'h2469);
        chk("post_load_cnt", {32'd0, a_cnt}, 64'd1);

        // advance with enable dropping completes, then parks in IDLE
        a_enable = 1'b0;
        tick();
        chk("drop_data", a_data, 64'h48D3);
        chk("drop_cnt", {32'd0, a_cnt}, 64'd2);
        chk("drop_valid", {63'd0, a_valid}, 64'd0);
        tick();
        chk("idle_hold_data", a_data, 64'h48D3);
        chk("idle_hold_cnt", {32'd0, a_cnt}, 64'd2);

        a_load = 1'b1; a_seed = 64'h55;
        tick();
        a_load = 1'b0;
        chk("idle_load_data", a_data, 64'h55);
        chk("idle_load_cnt", {32'd0, a_cnt}, 64'd0);
        chk("idle_load_valid", {63'd0, a_valid}, 64'd0);
        tick();
        chk("idle_load_hold", a_data, 64'h55);
        chk("idle_load_valid2", {63'd0, a_valid}, 64'd0);

        // reset wins over load and enable
        a_reset = 1'b1; a_load = 1'b1; a_enable = 1'b1; a_seed = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        a_reset = 1'b0; a_load = 1'b0;
        chk("rst2_valid", {63'd0, a_valid}, 64'd0);
        chk("rst2_data", a_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
`ifdef LFSR_LOCKUP_EN
        chk("lk_run_valid", {63'd0, a_valid}, 64'd0);
        chk("lk_run_lockup", {63'd0, a_lockup}, 64'd0);
        tick();
        chk("lk_locked_lockup", {63'd0, a_lockup}, 64'd1);
        chk("lk_locked_valid", {63'd0, a_valid}, 64'd0);
        tick();
        chk("lk_stay_lockup", {63'd0, a_lockup}, 64'd1);
        chk("lk_stay_cnt", {32'd0, a_cnt}, 64'd0);
        a_load = 1'b1; a_seed = 64'h0;
        tick();
        a_load = 1'b0;
        chk("lk_exit_lockup", {63'd0, a_lockup}, 64'd0);
        chk("lk_exit_valid", {63'd0, a_valid}, 64'd1);
        chk("lk_exit_data", a_data, 64'h0);
`else
        chk("ones_valid", {63'd0, a_valid}, 64'd1);
        chk("ones_data", a_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_cnt0", {32'd0, a_cnt}, 64'd0);
        tick();
        chk("ones_data1", a_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_cnt1", {32'd0, a_cnt}, 64'd1);
        chk("ones_lockup", {63'd0, a_lockup}, 64'd0);
        tick();
        chk("ones_cnt2", {32'd0, a_cnt}, 64'd2);
        chk("ones_valid2", {63'd0, a_valid}, 64'd1);
`endif

        // 8-bit instance: one advance applies eight single steps
        b_enable = 1'b1;
        tick();
        chk("b_valid", {63'd0, b_valid}, 64'd1);
        chk("b_data0", {56'd0, b_data}, 64'h00);
        tick();
        chk("b_data1", {56'd0, b_data}, 64'hF4);
        chk("b_cnt1", {32'd0, b_cnt}, 64'd1);
        chk("b_lockup", {63'd0, b_lockup}, 64'd0);
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        chk("b_rst_valid", {63'd0, b_valid}, 64'd0);
        chk("b_rst_data", {56'd0, b_data}, 64'h00);
        chk("b_rst_cnt", {32'd0, b_cnt}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
